// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide sequencer.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULLO = 2'b00,
    OP_MULHI = 2'b01,
    OP_DIVU  = 2'b10,
    OP_REMU  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  typedef enum logic {
    MODE_MUL,
    MODE_DIV
  } mode_t;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between the control unit and the multiply/divide engine.
interface muldiv_sequencer_if #(
  parameter int unsigned l = 16
);
  logic         Start;
  logic [1:0]   Op;
  logic [l-1:0] A;
  logic [l-1:0] B;
  logic         Stall;
  logic         Busy;
  logic         Done;
  logic [l-1:0] Result;
  logic         DivByZero;

  modport master (
    output Start, Op, A, B,
    input  Stall, Busy, Done, Result, DivByZero
  );

  modport slave (
    input  Start, Op, A, B,
    output Stall, Busy, Done, Result, DivByZero
  );
endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration of shift-add multiply or restoring divide,
// sharing a single FullAdder ripple chain for the add and the trial subtract.
module FullAdder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);
  assign S    = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned l = 16
) (
  input  mode_t        Mode,
  input  logic [l-1:0] HiIn,
  input  logic [l-1:0] LoIn,
  input  logic [l-1:0] B,
  output logic [l-1:0] HiOut,
  output logic [l-1:0] LoOut
);
  // The remainder never exceeds l bits between iterations (it stays below B),
  // so only the shifted value inside this step needs the extra bit.
  logic [l:0]   shR;
  logic [l-1:0] shQ;
  logic [l:0]   addX;
  logic [l:0]   addY;
  logic [l:0]   sum;
  logic [l+1:0] carry;

  assign shR = {HiIn, LoIn[l-1]};
  assign shQ = {LoIn[l-2:0], 1'b0};

  always_comb begin
    addX     = {1'b0, HiIn};
    addY     = '0;
    carry[0] = 1'b0;
    if (Mode == MODE_DIV) begin
      addX     = shR;
      addY     = ~{1'b0, B};
      carry[0] = 1'b1;
    end else if (LoIn[0]) begin
      addY = {1'b0, B};
    end
  end

  for (genvar i = 0; i <= l; i++) begin : g_fa
    FullAdder fa (
      .A   (addX[i]),
      .B   (addY[i]),
      .Cin (carry[i]),
      .S   (sum[i]),
      .Cout(carry[i+1])
    );
  end

  always_comb begin
    HiOut = sum[l:1];
    LoOut = {sum[0], LoIn[l-1:1]};
    if (Mode == MODE_DIV) begin
      // Carry out of the trial subtract means the difference is non-negative.
      if (carry[l+1]) begin
        HiOut = sum[l-1:0];
        LoOut = {shQ[l-1:1], 1'b1};
      end else begin
        HiOut = shR[l-1:0];
        LoOut = shQ;
      end
    end
  end
endmodule

// File: rtl/muldiv_sequencer.sv
// Control FSM, iteration counter and operand/result registers for the
// multi-cycle multiply/divide engine behind the ALU.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned l  = 16,
  parameter int unsigned cw = 5
) (
  input  logic                 Clk,
  input  logic                 ResetN,
  muldiv_sequencer_if.slave    bus
);
  state_t       state;
  state_t       stateNext;
  logic [cw-1:0] cnt;
  logic [l-1:0] accHi;
  logic [l-1:0] accLo;
  logic [l-1:0] bReg;
  op_t          opReg;
  logic [l-1:0] resultReg;
  logic         dbzReg;

  logic [l-1:0] stepHi;
  logic [l-1:0] stepLo;
  logic [l-1:0] runResult;
  logic         lastIter;
  logic         startDbz;
  mode_t        mode;

  assign mode     = opReg[1] ? MODE_DIV : MODE_MUL;
  assign lastIter = (state == S_RUN) && (cnt == cw'(l - 1));
  assign startDbz = bus.Op[1] && (bus.B == '0);

  // accHi/accLo hold P's upper/lower halves when multiplying, R/Q when dividing.
  muldiv_step #(.l(l)) step (
    .Mode (mode),
    .HiIn (accHi),
    .LoIn (accLo),
    .B    (bReg),
    .HiOut(stepHi),
    .LoOut(stepLo)
  );

  always_comb begin
    runResult = stepLo;
    case (opReg)
      OP_MULLO: runResult = stepLo;
      OP_MULHI: runResult = stepHi;
      OP_DIVU:  runResult = stepLo;
      OP_REMU:  runResult = stepHi;
      default:  runResult = stepLo;
    endcase
  end

  always_comb begin
    stateNext = state;
    case (state)
      S_IDLE:  if (bus.Start) stateNext = startDbz ? S_DONE : S_RUN;
      S_RUN:   if (lastIter) stateNext = S_DONE;
      S_DONE:  stateNext = S_IDLE;
      default: stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state     <= S_IDLE;
      cnt       <= '0;
      accHi     <= '0;
      accLo     <= '0;
      bReg      <= '0;
      opReg     <= OP_MULLO;
      resultReg <= '0;
      dbzReg    <= 1'b0;
    end else begin
      state <= stateNext;
      case (state)
        S_IDLE: begin
          if (bus.Start) begin
            opReg <= op_t'(bus.Op);
            bReg  <= bus.B;
            accHi <= '0;
            accLo <= bus.A;
            cnt   <= '0;
            if (startDbz) begin
              resultReg <= (bus.Op == OP_DIVU) ? '1 : bus.A;
              dbzReg    <= 1'b1;
            end else begin
              resultReg <= '0;
              dbzReg    <= 1'b0;
            end
          end
        end
        S_RUN: begin
          accHi <= stepHi;
          accLo <= stepLo;
          cnt   <= cnt + cw'(1);
          if (lastIter) resultReg <= runResult;
        end
        default: ;
      endcase
    end
  end

  assign bus.Stall     = ((state == S_IDLE) && bus.Start) || (state == S_RUN);
  assign bus.Busy      = (state != S_IDLE);
  assign bus.Done      = (state == S_DONE);
  assign bus.Result    = resultReg;
  assign bus.DivByZero = dbzReg;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench: cycle-level reference model plus directed literal vectors.
module tb_muldiv_sequencer;
  localparam int L = 16;

  logic Clk = 1'b0;
  logic ResetN = 1'b0;
  int   nCmp = 0;
  int   nFail = 0;
  int   cyc = 0;

  muldiv_sequencer_if #(.l(L)) bus ();

  muldiv_sequencer #(.l(L), .cw(5)) dut (
    .Clk   (Clk),
    .ResetN(ResetN),
    .bus   (bus.slave)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] refResult(input logic [1:0] op, input logic [15:0] a,
                                            input logic [15:0] b);
    logic [31:0] p;
    p = {16'h0, a} * {16'h0, b};
    case (op)
      2'b00:   return p[15:0];
      2'b01:   return p[31:16];
      2'b10:   return (b == 16'h0) ? 16'hFFFF : a / b;
      default: return (b == 16'h0) ? a : a % b;
    endcase
  endfunction

  // Reference model: mPhase = cycles remaining until the Done cycle (0 = idle).
  int          mPhase = 0;
  logic [15:0] mRes = '0;
  logic        mDbz = 1'b0;
  logic [15:0] pend = '0;
  logic        pendDbz = 1'b0;
  int          accepts = 0;
  int          dutDones = 0;
  int          modelDones = 0;

  always @(negedge Clk) begin
    if (!ResetN) begin
      mPhase = 0;
      mRes   = '0;
      mDbz   = 1'b0;
    end
    check("busy", 32'(bus.Busy), 32'(mPhase > 0));
    check("done", 32'(bus.Done), 32'(mPhase == 1));
    check("stall", 32'(bus.Stall), 32'((mPhase == 0 && bus.Start) || mPhase > 1));
    check("result", 32'(bus.Result), 32'(mRes));
    check("divbyzero", 32'(bus.DivByZero), 32'(mDbz));
    if (bus.Done) dutDones++;
    if (mPhase == 1) modelDones++;
    if (ResetN) begin
      if (mPhase == 0) begin
        if (bus.Start) begin
          accepts++;
          pend    = refResult(bus.Op, bus.A, bus.B);
          pendDbz = bus.Op[1] && (bus.B == 16'h0);
          mRes    = '0;
          mDbz    = 1'b0;
          if (pendDbz) begin
            mPhase = 1;
            mRes   = pend;
            mDbz   = 1'b1;
          end else begin
            mPhase = L + 1;
          end
        end
      end else begin
        mPhase--;
        if (mPhase == 1) begin
          mRes = pend;
          mDbz = pendDbz;
        end
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    @(posedge Clk);
    #1;
    bus.Start = 1'b1;
    bus.Op    = op;
    bus.A     = a;
    bus.B     = b;
    @(posedge Clk);
    #1;
    bus.Start = 1'b0;
  endtask

  // Waits (bounded) for Done; returns cycles since acceptance and stall count before Done.
  task automatic waitDone(output int lat, output int stl, output bit got);
    lat = 0;
    stl = 0;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      lat++;
      if (bus.Done) begin
        got = 1'b1;
        break;
      end
      if (bus.Stall) stl++;
    end
    check("done_within_bound", 32'(got), 32'd1);
  endtask

  task automatic doOp(input string name, input logic [1:0] op, input logic [15:0] a,
                      input logic [15:0] b, input logic [15:0] expRes, input logic expDbz,
                      input int expLat);
    int lat;
    int stl;
    bit got;
    issue(op, a, b);
    waitDone(lat, stl, got);
    if (got) begin
      check({name, "_latency"}, 32'(lat), 32'(expLat));
      check({name, "_result"}, 32'(bus.Result), 32'(expRes));
      check({name, "_dbz"}, 32'(bus.DivByZero), 32'(expDbz));
      check({name, "_stall_in_done"}, 32'(bus.Stall), 32'd0);
      if (expLat > 1) check({name, "_run_stall_cycles"}, 32'(stl), 32'(expLat - 1));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int   lat;
    int   stl;
    bit   got;
    int   firstDone;
    logic [1:0]  rop;
    logic [15:0] ra;
    logic [15:0] rb;

    bus.Start = 1'b0;
    bus.Op    = 2'b00;
    bus.A     = '0;
    bus.B     = '0;
    #1;
    check("reset_busy", 32'(bus.Busy), 32'd0);
    check("reset_done", 32'(bus.Done), 32'd0);
    check("reset_result", 32'(bus.Result), 32'd0);
    check("reset_dbz", 32'(bus.DivByZero), 32'd0);
    repeat (2) @(posedge Clk);
    #1 ResetN = 1'b1;

    // Reset mid-RUN aborts the operation.
    issue(2'b00, 16'd7, 16'd9);
    repeat (4) @(posedge Clk);
    #1 ResetN = 1'b0;
    #1;
    check("midreset_busy", 32'(bus.Busy), 32'd0);
    check("midreset_done", 32'(bus.Done), 32'd0);
    check("midreset_result", 32'(bus.Result), 32'd0);
    repeat (2) @(posedge Clk);
    #1 ResetN = 1'b1;
    doOp("after_reset", 2'b00, 16'd7, 16'd9, 16'd63, 1'b0, 17);

    doOp("mullo_1234", 2'b00, 16'h1234, 16'h0010, 16'h2340, 1'b0, 17);
    doOp("mulhi_ffff", 2'b01, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0, 17);
    doOp("mullo_ffff", 2'b00, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 17);
    doOp("divu_100_7", 2'b10, 16'd100, 16'd7, 16'd14, 1'b0, 17);
    doOp("remu_100_7", 2'b11, 16'd100, 16'd7, 16'd2, 1'b0, 17);
    doOp("divu_5_9", 2'b10, 16'd5, 16'd9, 16'd0, 1'b0, 17);
    doOp("remu_5_9", 2'b11, 16'd5, 16'd9, 16'd5, 1'b0, 17);
    doOp("divu_by0", 2'b10, 16'h0042, 16'h0000, 16'hFFFF, 1'b1, 1);
    doOp("remu_by0", 2'b11, 16'h0042, 16'h0000, 16'h0042, 1'b1, 1);

    // Start pulses during RUN and DONE are ignored; next IDLE Start is accepted.
    issue(2'b00, 16'd3, 16'd5);
    repeat (5) @(posedge Clk);
    #1;
    bus.Start = 1'b1;
    bus.Op    = 2'b10;
    bus.A     = 16'd100;
    bus.B     = 16'd0;
    @(posedge Clk);
    #1 bus.Start = 1'b0;
    waitDone(lat, stl, got);
    firstDone = cyc;
    check("busy_first_result", 32'(bus.Result), 32'd15);
    check("busy_first_dbz", 32'(bus.DivByZero), 32'd0);
    #1;
    bus.Start = 1'b1;
    bus.Op    = 2'b11;
    bus.A     = 16'd1234;
    bus.B     = 16'd0;
    @(posedge Clk);
    #1;
    bus.Op = 2'b01;
    bus.A  = 16'h8000;
    bus.B  = 16'd4;
    @(posedge Clk);
    #1 bus.Start = 1'b0;
    waitDone(lat, stl, got);
    check("b2b_result", 32'(bus.Result), 32'd2);
    check("b2b_interval", 32'(cyc - firstDone), 32'd18);

    // Random regression; the model checks every cycle.
    for (int n = 0; n < 2000; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = 16'($urandom);
      rb  = ($urandom_range(0, 99) < 5) ? 16'h0 : 16'($urandom);
      if ($urandom_range(0, 9) == 0) rb = 16'($urandom_range(1, 15));
      issue(rop, ra, rb);
      waitDone(lat, stl, got);
    end

    @(negedge Clk);
    check("done_count_vs_model", 32'(dutDones), 32'(modelDones));
    check("done_per_accepted_start", 32'(dutDones), 32'(accepts - 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end
endmodule
